// File: rtl/vector_write_back_pkg.sv
// Shared definitions for the vector write-back stage: default geometry,
// SEW encoding and the SEW-to-element-count mapping.
package vector_write_back_pkg;

    localparam int VWB_VRF_WIDTH     = 128;
    localparam int VWB_VRF_DEPTH     = 32;
    localparam int VWB_WB_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        SEW_E8  = 2'b00,
        SEW_E16 = 2'b01,
        SEW_E32 = 2'b10,
        SEW_E64 = 2'b11
    } vsew_e;

    // Number of SEW-wide elements held in one register of vlen bits.
    function automatic int unsigned elem_count(input vsew_e sew, input int unsigned vlen);
        return vlen >> (32'd3 + 32'(sew));
    endfunction

endpackage

// File: rtl/vector_write_back_if.sv
// Result/VRF-write/hazard bundle between the execution units, the write-back
// stage, the register file write port and decode.
interface vector_write_back_if
    import vector_write_back_pkg::*;
#(
    parameter int VRF_WIDTH         = VWB_VRF_WIDTH,
    parameter int VRF_DEPTH         = VWB_VRF_DEPTH,
    parameter int VRF_ADDRESS_WIDTH = $clog2(VRF_DEPTH),
    parameter int WB_FIFO_DEPTH     = VWB_WB_FIFO_DEPTH,
    parameter int VL_WIDTH          = $clog2(VRF_WIDTH / 8) + 1
) ();

    logic                               result_valid_i;
    logic                               result_ready_o;
    logic [VRF_WIDTH-1:0]               result_data_i;
    logic [VRF_WIDTH-1:0]               vd_old_data_i;
    logic [VRF_WIDTH-1:0]               vmask_data_i;
    logic                               vm_i;
    logic [1:0]                         vsew_i;
    logic [VL_WIDTH-1:0]                vl_i;
    logic [VRF_ADDRESS_WIDTH-1:0]       vd_address_i;
    logic                               stall_i;
    logic [VRF_ADDRESS_WIDTH-1:0]       hazard_address_i;
    logic                               hazard_o;
    logic                               vd_write_enable_o;
    logic [VRF_ADDRESS_WIDTH-1:0]       vd_write_address_o;
    logic [VRF_WIDTH-1:0]               vd_write_data_o;
    logic [$clog2(WB_FIFO_DEPTH):0]     occupancy_o;

    modport slave (
        input  result_valid_i, result_data_i, vd_old_data_i, vmask_data_i, vm_i,
               vsew_i, vl_i, vd_address_i, stall_i, hazard_address_i,
        output result_ready_o, hazard_o, vd_write_enable_o, vd_write_address_o,
               vd_write_data_o, occupancy_o
    );

    modport master (
        output result_valid_i, result_data_i, vd_old_data_i, vmask_data_i, vm_i,
               vsew_i, vl_i, vd_address_i, stall_i, hazard_address_i,
        input  result_ready_o, hazard_o, vd_write_enable_o, vd_write_address_o,
               vd_write_data_o, occupancy_o
    );

endinterface

// File: rtl/vector_write_back_merge.sv
// Combinational element merge: active elements take the new result, masked-off
// and tail elements keep the old destination contents (undisturbed policy).
module vector_mask_merge_unit
    import vector_write_back_pkg::*;
#(
    parameter int VRF_WIDTH = VWB_VRF_WIDTH,
    parameter int VL_WIDTH  = $clog2(VRF_WIDTH / 8) + 1
) (
    input  logic [VRF_WIDTH-1:0] result_data_i,
    input  logic [VRF_WIDTH-1:0] vd_old_data_i,
    input  logic [VRF_WIDTH-1:0] vmask_data_i,
    input  logic                 vm_i,
    input  logic [1:0]           vsew_i,
    input  logic [VL_WIDTH-1:0]  vl_i,
    output logic [VRF_WIDTH-1:0] merged_data_o
);

    localparam int NBYTES = VRF_WIDTH / 8;

    vsew_e               sew_s;
    logic [VL_WIDTH-1:0] elem_s;
    logic                active_s;

    assign sew_s = vsew_e'(vsew_i);

    // Work byte by byte: each byte inherits the active state of its owning element.
    always_comb begin
        merged_data_o = vd_old_data_i;
        elem_s        = {VL_WIDTH{1'b0}};
        active_s      = 1'b0;
        for (int b = 0; b < NBYTES; b++) begin
            case (sew_s)
                SEW_E8:  elem_s = VL_WIDTH'(b);
                SEW_E16: elem_s = VL_WIDTH'(b) >> 1;
                SEW_E32: elem_s = VL_WIDTH'(b) >> 2;
                SEW_E64: elem_s = VL_WIDTH'(b) >> 3;
                default: elem_s = VL_WIDTH'(b);
            endcase
            active_s = (elem_s < vl_i) && (vm_i || vmask_data_i[elem_s]);
            if (active_s) begin
                merged_data_o[b*8 +: 8] = result_data_i[b*8 +: 8];
            end else begin
                merged_data_o[b*8 +: 8] = vd_old_data_i[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/vector_write_back.sv
// Vector write-back stage: merges results, buffers them in a small FIFO that
// drives the VRF write port, and flags pending destinations for decode.
module vector_write_back
    import vector_write_back_pkg::*;
#(
    parameter int VRF_WIDTH         = VWB_VRF_WIDTH,
    parameter int VRF_DEPTH         = VWB_VRF_DEPTH,
    parameter int VRF_ADDRESS_WIDTH = $clog2(VRF_DEPTH),
    parameter int WB_FIFO_DEPTH     = VWB_WB_FIFO_DEPTH,
    parameter int VL_WIDTH          = $clog2(VRF_WIDTH / 8) + 1
) (
    input logic                clk_i,
    input logic                rst_i,
    vector_write_back_if.slave bus
);

    localparam int PTR_W = $clog2(WB_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [VRF_WIDTH-1:0]         merged_s;
    logic [VRF_WIDTH-1:0]         data_mem_q [WB_FIFO_DEPTH];
    logic [VRF_ADDRESS_WIDTH-1:0] addr_mem_q [WB_FIFO_DEPTH];
    logic [WB_FIFO_DEPTH-1:0]     valid_q, valid_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         full_s, empty_s, push_s, pop_s, hazard_s;

    vector_mask_merge_unit #(
        .VRF_WIDTH (VRF_WIDTH),
        .VL_WIDTH  (VL_WIDTH)
    ) u_merge (
        .result_data_i (bus.result_data_i),
        .vd_old_data_i (bus.vd_old_data_i),
        .vmask_data_i  (bus.vmask_data_i),
        .vm_i          (bus.vm_i),
        .vsew_i        (bus.vsew_i),
        .vl_i          (bus.vl_i),
        .merged_data_o (merged_s)
    );

    // Readiness depends only on fullness, so a pop never opens a same-cycle slot.
    assign full_s  = (count_q == CNT_W'(WB_FIFO_DEPTH));
    assign empty_s = (count_q == {CNT_W{1'b0}});
    assign push_s  = bus.result_valid_i && !full_s;
    assign pop_s   = !empty_s && !bus.stall_i;

    // Next-state for pointers, occupancy and per-entry valid bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (pop_s) begin
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
            valid_d[rd_ptr_q] = 1'b0;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s) begin
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            valid_d[wr_ptr_q] = 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Control state register with synchronous reset; discards all buffered entries.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            valid_q  <= {WB_FIFO_DEPTH{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Entry storage; only valid bits qualify it, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            data_mem_q[wr_ptr_q] <= merged_s;
            addr_mem_q[wr_ptr_q] <= bus.vd_address_i;
        end
    end

    // RAW hazard: any still-unwritten entry, including the head being written now.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
            if (valid_q[i] && (addr_mem_q[i] == bus.hazard_address_i)) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    assign bus.result_ready_o     = !full_s;
    assign bus.hazard_o           = hazard_s;
    assign bus.vd_write_enable_o  = pop_s;
    assign bus.vd_write_address_o = addr_mem_q[rd_ptr_q];
    assign bus.vd_write_data_o    = data_mem_q[rd_ptr_q];
    assign bus.occupancy_o        = count_q;

endmodule

// File: tb/tb_vector_write_back.sv
// Randomized self-checking bench for vector_write_back against a queue-based
// reference model of the write-back buffer and element merge rules.
module tb_vector_write_back;

    localparam int W   = 128;
    localparam int AW  = 5;
    localparam int VLW = 5;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } entry_t;

    logic   clk = 1'b0;
    logic   rst;
    int     tests_run    = 0;
    int     tests_failed = 0;
    entry_t model_q[$];

    always #5 clk = ~clk;

    vector_write_back_if bus ();

    vector_write_back dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Element-level merge straight from the rules: element i active iff i<vl and (vm or mask[i]).
    function automatic logic [W-1:0] ref_merge(input logic [W-1:0] res, input logic [W-1:0] old,
                                               input logic [W-1:0] mask, input logic vm,
                                               input logic [1:0] vsew, input logic [VLW-1:0] vl);
        int sew;
        int n;
        logic [W-1:0] out;
        sew = 8 << vsew;
        n   = W / sew;
        out = old;
        for (int i = 0; i < n; i++) begin
            if ((i < int'(vl)) && (vm || mask[i])) begin
                for (int b = 0; b < sew; b++) out[i*sew + b] = res[i*sew + b];
            end
        end
        return out;
    endfunction

    task automatic step(input logic valid, input logic stall, input logic [1:0] vsew,
                        input logic [VLW-1:0] vl, input logic vm, input logic [W-1:0] mask,
                        input logic [W-1:0] res, input logic [W-1:0] old,
                        input logic [AW-1:0] addr, input logic [AW-1:0] haddr,
                        input logic chk, input logic [W-1:0] want);
        logic   exp_ready;
        logic   exp_en;
        logic   exp_haz;
        entry_t e;
        @(negedge clk);
        bus.result_valid_i   = valid;
        bus.stall_i          = stall;
        bus.vsew_i           = vsew;
        bus.vl_i             = vl;
        bus.vm_i             = vm;
        bus.vmask_data_i     = mask;
        bus.result_data_i    = res;
        bus.vd_old_data_i    = old;
        bus.vd_address_i     = addr;
        bus.hazard_address_i = haddr;
        #1;
        exp_ready = (model_q.size() < 2);
        exp_en    = (model_q.size() > 0) && !stall;
        exp_haz   = 1'b0;
        foreach (model_q[k]) if (model_q[k].addr == haddr) exp_haz = 1'b1;
        check_val("ready", W'(bus.result_ready_o), W'(exp_ready));
        check_val("wr_en", W'(bus.vd_write_enable_o), W'(exp_en));
        check_val("occupancy", W'(bus.occupancy_o), W'(model_q.size()));
        check_val("hazard", W'(bus.hazard_o), W'(exp_haz));
        if (exp_en) begin
            check_val("wr_addr", W'(bus.vd_write_address_o), W'(model_q[0].addr));
            check_val("wr_data", bus.vd_write_data_o, model_q[0].data);
        end
        if (chk) check_val("wr_data_const", bus.vd_write_data_o, want);
        @(posedge clk);
        if (exp_en) void'(model_q.pop_front());
        if (valid && exp_ready) begin
            e.addr = addr;
            e.data = ref_merge(res, old, mask, vm, vsew, vl);
            model_q.push_back(e);
        end
    endtask

    task automatic idle(input logic stall, input logic [AW-1:0] haddr);
        step(1'b0, stall, 2'd0, 5'd0, 1'b1, '0, '0, '0, 5'd0, haddr, 1'b0, '0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst                = 1'b1;
        bus.result_valid_i = 1'b0;
        bus.stall_i        = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_q.delete();
        @(negedge clk);
        check_val("rst_ready", W'(bus.result_ready_o), W'(1'b1));
        check_val("rst_wr_en", W'(bus.vd_write_enable_o), W'(1'b0));
        check_val("rst_occupancy", W'(bus.occupancy_o), W'(0));
        check_val("rst_hazard", W'(bus.hazard_o), W'(1'b0));
    endtask

    logic [W-1:0] r1, r2, r3, rm, om, ra, oa;
    logic [W-1:0] rnd_mask, rnd_res, rnd_old;
    logic [AW-1:0] rnd_haddr;

    initial begin
        rst                  = 1'b1;
        bus.result_valid_i   = 1'b0;
        bus.stall_i          = 1'b0;
        bus.vsew_i           = 2'd0;
        bus.vl_i             = 5'd0;
        bus.vm_i             = 1'b1;
        bus.vmask_data_i     = '0;
        bus.result_data_i    = '0;
        bus.vd_old_data_i    = '0;
        bus.vd_address_i     = 5'd0;
        bus.hazard_address_i = 5'd0;
        repeat (2) @(posedge clk);
        apply_reset();

        // Unmasked e32, vl=4: write data equals result one cycle after accept.
        r1 = 128'h44444444_33333333_22222222_11111111;
        step(1'b1, 1'b0, 2'd2, 5'd4, 1'b1, '0, r1, {W{1'b1}}, 5'd1, 5'd0, 1'b0, '0);
        step(1'b0, 1'b0, 2'd0, 5'd0, 1'b1, '0, '0, '0, 5'd0, 5'd0, 1'b1, r1);

        // Masked e8: v0=0xA5 selects bytes 0,2,5,7.
        rm = {16{8'h11}};
        om = {16{8'hEE}};
        step(1'b1, 1'b0, 2'd0, 5'd16, 1'b0, 128'hA5, rm, om, 5'd2, 5'd0, 1'b0, '0);
        step(1'b0, 1'b0, 2'd0, 5'd0, 1'b1, '0, '0, '0, 5'd0, 5'd0, 1'b1,
             128'hEEEEEEEEEEEEEEEE_11EE11EEEE11EE11);

        // Tail e64 vl=1, then vl=0 leaves the old contents.
        ra = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
        oa = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        step(1'b1, 1'b0, 2'd3, 5'd1, 1'b1, '0, ra, oa, 5'd3, 5'd0, 1'b0, '0);
        step(1'b1, 1'b0, 2'd3, 5'd0, 1'b1, '0, ra, oa, 5'd4, 5'd0, 1'b1, {oa[127:64], ra[63:0]});
        step(1'b0, 1'b0, 2'd0, 5'd0, 1'b1, '0, '0, '0, 5'd0, 5'd0, 1'b1, oa);

        // Stall with three back-to-back results, then release.
        r2 = {$urandom, $urandom, $urandom, $urandom};
        r3 = {$urandom, $urandom, $urandom, $urandom};
        step(1'b1, 1'b1, 2'd2, 5'd4, 1'b1, '0, r1, '0, 5'd10, 5'd0, 1'b0, '0);
        step(1'b1, 1'b1, 2'd2, 5'd4, 1'b1, '0, r2, '0, 5'd11, 5'd0, 1'b0, '0);
        step(1'b1, 1'b1, 2'd2, 5'd4, 1'b1, '0, r3, '0, 5'd12, 5'd0, 1'b0, '0);
        check_val("stall_occupancy", W'(bus.occupancy_o), W'(2));
        step(1'b1, 1'b0, 2'd2, 5'd4, 1'b1, '0, r3, '0, 5'd12, 5'd0, 1'b1, r1);
        step(1'b1, 1'b0, 2'd2, 5'd4, 1'b1, '0, r3, '0, 5'd12, 5'd0, 1'b1, r2);
        step(1'b0, 1'b0, 2'd0, 5'd0, 1'b1, '0, '0, '0, 5'd0, 5'd0, 1'b1, r3);
        idle(1'b0, 5'd0);

        // Hazard on a buffered v5 entry, including the cycle it is written.
        step(1'b1, 1'b1, 2'd2, 5'd4, 1'b1, '0, r2, '0, 5'd5, 5'd0, 1'b0, '0);
        idle(1'b1, 5'd5);
        idle(1'b1, 5'd6);
        idle(1'b0, 5'd5);
        idle(1'b0, 5'd5);

        // Reset with two entries buffered.
        step(1'b1, 1'b1, 2'd1, 5'd8, 1'b1, '0, r1, '0, 5'd7, 5'd0, 1'b0, '0);
        step(1'b1, 1'b1, 2'd1, 5'd8, 1'b1, '0, r2, '0, 5'd8, 5'd0, 1'b0, '0);
        apply_reset();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            rnd_mask  = {$urandom, $urandom, $urandom, $urandom};
            rnd_res   = {$urandom, $urandom, $urandom, $urandom};
            rnd_old   = {$urandom, $urandom, $urandom, $urandom};
            rnd_haddr = AW'($urandom_range(0, 31));
            if ((model_q.size() > 0) && ($urandom_range(0, 1) == 1)) begin
                rnd_haddr = model_q[model_q.size() - 1].addr;
            end
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)), VLW'($urandom_range(0, 20)),
                 1'($urandom_range(0, 1)), rnd_mask, rnd_res, rnd_old,
                 AW'($urandom_range(0, 31)), rnd_haddr, 1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
